// File: rtl/dallanma_ongorucu_pkg.sv
// Shared sizes, bit positions and counter encodings for the
// gshare branch predictor and its target buffer.
package dallanma_ongorucu_pkg;

  localparam int BTB_SATIR_VARSAYILAN = 32;
  localparam int PHT_SATIR_VARSAYILAN = 64;
  localparam int GGK_BIT_VARSAYILAN   = 6;

  localparam int PS_BIT      = 32;
  localparam int IDX_LSB     = 2;
  localparam int BTB_IDX_MSB = 6;
  localparam int BTB_TAG_LSB = 7;
  localparam int BTB_TAG_MSB = 31;
  localparam int PHT_IDX_MSB = 7;

  typedef enum logic [1:0] {
    GUCLU_ATLAMAZ = 2'b00,
    ZAYIF_ATLAMAZ = 2'b01,
    ZAYIF_ATLAR   = 2'b10,
    GUCLU_ATLAR   = 2'b11
  } pht_sayac_e;

  // Saturating 2-bit step toward the resolved direction.
  function automatic pht_sayac_e sayac_adim(
    input pht_sayac_e s,
    input logic       atladi
  );
    pht_sayac_e r;
    r = s;
    if (atladi) begin
      if (s != GUCLU_ATLAR) r = pht_sayac_e'(s + 2'd1);
    end else begin
      if (s != GUCLU_ATLAMAZ) r = pht_sayac_e'(s - 2'd1);
    end
    return r;
  endfunction

  function automatic logic [31:0] doygun_artir(
    input logic [31:0] x
  );
    return (&x) ? x : x + 32'd1;
  endfunction

endpackage

// File: rtl/dal_hedef_tamponu.sv
// Branch target buffer: direct mapped, one read and one write port.
// Ports: oku_ps_i -> oku_isabet_o/oku_hedef_o; yaz_i writes yaz_ps_i tag + yaz_hedef_i.
module dal_hedef_tamponu
  import dallanma_ongorucu_pkg::*;
#(
  parameter int SATIR = BTB_SATIR_VARSAYILAN
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] oku_ps_i,
  output logic        oku_isabet_o,
  output logic [31:0] oku_hedef_o,
  input  logic        yaz_i,
  input  logic [31:0] yaz_ps_i,
  input  logic [31:0] yaz_hedef_i
);

  localparam int IW = $clog2(SATIR);
  localparam int TW = PS_BIT - IW - IDX_LSB;

  logic          gecerli [SATIR];
  logic [TW-1:0] etiket  [SATIR];
  logic [31:0]   hedef   [SATIR];

  logic [IW-1:0] oku_idx;
  logic [IW-1:0] yaz_idx;
  logic [TW-1:0] oku_etiket;
  logic [TW-1:0] yaz_etiket;
  logic          unused_bitler;

  assign oku_idx    = oku_ps_i[IDX_LSB +: IW];
  assign yaz_idx    = yaz_ps_i[IDX_LSB +: IW];
  assign oku_etiket = oku_ps_i[PS_BIT-1 -: TW];
  assign yaz_etiket = yaz_ps_i[PS_BIT-1 -: TW];

  // Byte offset of the PC never selects an entry.
  assign unused_bitler = ^{oku_ps_i[1:0], yaz_ps_i[1:0]};

  assign oku_isabet_o = gecerli[oku_idx] &&
                        (etiket[oku_idx] == oku_etiket);
  assign oku_hedef_o  = hedef[oku_idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SATIR; i++) gecerli[i] <= 1'b0;
    end else if (yaz_i) begin
      gecerli[yaz_idx] <= 1'b1;
    end
  end

  // Tag and target are qualified by the valid bit, so no reset.
  always_ff @(posedge clk_i) begin
    if (yaz_i && !rst_i) begin
      etiket[yaz_idx] <= yaz_etiket;
      hedef[yaz_idx]  <= yaz_hedef_i;
    end
  end

endmodule

// File: rtl/dallanma_ongorucu.sv
// Gshare direction predictor with BTB, non-speculative history and
// saturating branch/mispredict counters.
// Ports: ps_i -> ongoru_*; guncelle_* resolves; sayac_* are perf counters.
module dallanma_ongorucu
  import dallanma_ongorucu_pkg::*;
#(
  parameter int BTB_SATIR = BTB_SATIR_VARSAYILAN,
  parameter int PHT_SATIR = PHT_SATIR_VARSAYILAN,
  parameter int GGK_BIT   = GGK_BIT_VARSAYILAN
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ps_i,
  output logic        ongoru_gecerli_o,
  output logic        ongoru_atladi_o,
  output logic [31:0] ongoru_hedef_o,
  input  logic        guncelle_gecerli_i,
  input  logic        guncelle_atladi_i,
  input  logic [31:0] guncelle_ps_i,
  input  logic [31:0] guncelle_hedef_adresi_i,
  input  logic        dallanma_hata_i,
  output logic [31:0] sayac_dallanma_o,
  output logic [31:0] sayac_hata_o
);

  pht_sayac_e         pht [PHT_SATIR];
  logic [GGK_BIT-1:0] ggk;
  logic [31:0]        sayac_d;
  logic [31:0]        sayac_h;

  logic               btb_isabet;
  logic [31:0]        btb_hedef;
  logic [GGK_BIT-1:0] oku_idx;
  logic [GGK_BIT-1:0] yaz_idx;
  logic               isabet;
  logic               atladi;

  dal_hedef_tamponu #(
    .SATIR(BTB_SATIR)
  ) u_btb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .oku_ps_i    (ps_i),
    .oku_isabet_o(btb_isabet),
    .oku_hedef_o (btb_hedef),
    .yaz_i       (guncelle_gecerli_i && guncelle_atladi_i),
    .yaz_ps_i    (guncelle_ps_i),
    .yaz_hedef_i (guncelle_hedef_adresi_i)
  );

  assign oku_idx = ps_i[IDX_LSB +: GGK_BIT] ^ ggk;
  assign yaz_idx = guncelle_ps_i[IDX_LSB +: GGK_BIT] ^ ggk;

  // Gate with reset so outputs drop as soon as reset rises.
  assign isabet = btb_isabet && !rst_i;
  assign atladi = isabet && pht[oku_idx][1];

  assign ongoru_gecerli_o = isabet;
  assign ongoru_atladi_o  = atladi;
  assign ongoru_hedef_o   = atladi ? btb_hedef : ps_i + 32'd4;
  assign sayac_dallanma_o = sayac_d;
  assign sayac_hata_o     = sayac_h;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < PHT_SATIR; i++) pht[i] <= ZAYIF_ATLAMAZ;
      ggk     <= '0;
      sayac_d <= '0;
      sayac_h <= '0;
    end else if (guncelle_gecerli_i) begin
      pht[yaz_idx] <= sayac_adim(pht[yaz_idx], guncelle_atladi_i);
      ggk          <= {ggk[GGK_BIT-2:0], guncelle_atladi_i};
      sayac_d      <= doygun_artir(sayac_d);
      if (dallanma_hata_i) sayac_h <= doygun_artir(sayac_h);
    end
  end

endmodule

// File: tb/tb_dallanma_ongorucu.sv
// Scoreboard bench for dallanma_ongorucu: directed cases then random
// traffic, checked against a table-based reference model.
module tb_dallanma_ongorucu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] ps_i = '0;
  logic        ongoru_gecerli_o;
  logic        ongoru_atladi_o;
  logic [31:0] ongoru_hedef_o;
  logic        guncelle_gecerli_i = 1'b0;
  logic        guncelle_atladi_i = 1'b0;
  logic [31:0] guncelle_ps_i = '0;
  logic [31:0] guncelle_hedef_adresi_i = '0;
  logic        dallanma_hata_i = 1'b0;
  logic [31:0] sayac_dallanma_o;
  logic [31:0] sayac_hata_o;

  dallanma_ongorucu dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .ps_i                   (ps_i),
    .ongoru_gecerli_o       (ongoru_gecerli_o),
    .ongoru_atladi_o        (ongoru_atladi_o),
    .ongoru_hedef_o         (ongoru_hedef_o),
    .guncelle_gecerli_i     (guncelle_gecerli_i),
    .guncelle_atladi_i      (guncelle_atladi_i),
    .guncelle_ps_i          (guncelle_ps_i),
    .guncelle_hedef_adresi_i(guncelle_hedef_adresi_i),
    .dallanma_hata_i        (dallanma_hata_i),
    .sayac_dallanma_o       (sayac_dallanma_o),
    .sayac_hata_o           (sayac_hata_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] ps;
    logic        g;
    logic        a;
    logic [31:0] h;
    logic [31:0] sd;
    logic [31:0] sh;
  } beklenen_t;

  beklenen_t q[$];

  int karsilastirma = 0;
  int hata_sayisi   = 0;

  // Reference model: plain tables and integers.
  int          m_pht [64];
  int          m_ggk;
  bit          m_val [32];
  longint      m_tag [32];
  logic [31:0] m_hed [32];
  longint      m_sd;
  longint      m_sh;
  localparam longint MAKS = 64'hFFFF_FFFF;

  task automatic kontrol(input string ad, input logic [31:0] act,
                         input logic [31:0] exp);
    karsilastirma++;
    if (act !== exp) begin
      hata_sayisi++;
      $display("FAIL %s: got %h expected %h", ad, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    for (int i = 0; i < 32; i++) m_val[i] = 0;
    m_ggk = 0;
    m_sd  = 0;
    m_sh  = 0;
  endfunction

  function automatic beklenen_t model_ongoru(input logic [31:0] ps);
    beklenen_t e;
    int bi, pi;
    bit hit, tk;
    bi  = (ps / 4) % 32;
    pi  = ((ps / 4) % 64) ^ m_ggk;
    hit = m_val[bi] && (m_tag[bi] == longint'(ps / 128));
    tk  = hit && (m_pht[pi] >= 2);
    e.ps = ps;
    e.g  = hit;
    e.a  = tk;
    e.h  = tk ? m_hed[bi] : ps + 32'd4;
    e.sd = m_sd[31:0];
    e.sh = m_sh[31:0];
    return e;
  endfunction

  function automatic void model_guncelle(input logic [31:0] gps,
    input bit ga, input logic [31:0] gh, input bit hata);
    int pi, bi;
    pi = ((gps / 4) % 64) ^ m_ggk;
    bi = (gps / 4) % 32;
    if (ga) begin
      if (m_pht[pi] < 3) m_pht[pi]++;
      m_val[bi] = 1;
      m_tag[bi] = gps / 128;
      m_hed[bi] = gh;
    end else begin
      if (m_pht[pi] > 0) m_pht[pi]--;
    end
    m_ggk = ((m_ggk * 2) + int'(ga)) % 64;
    if (m_sd < MAKS) m_sd++;
    if (hata && m_sh < MAKS) m_sh++;
  endfunction

  // One cycle: drive just after a rising edge, queue the expected
  // prediction, then let the edge apply the update.
  task automatic adim(input logic [31:0] ps, input bit gv, input bit ga,
    input logic [31:0] gps, input logic [31:0] gh, input bit hata,
    input bit r);
    rst_i = r;
    ps_i = ps;
    guncelle_gecerli_i = gv;
    guncelle_atladi_i = ga;
    guncelle_ps_i = gps;
    guncelle_hedef_adresi_i = gh;
    dallanma_hata_i = hata;
    if (r) model_reset();
    q.push_back(model_ongoru(ps));
    @(posedge clk_i);
    if (!r && gv) model_guncelle(gps, ga, gh, hata);
    #1;
  endtask

  task automatic bos(input logic [31:0] ps);
    adim(ps, 0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic sifirla();
    adim(32'h0, 0, 0, 32'h0, 32'h0, 0, 1);
    adim(32'h0, 0, 0, 32'h0, 32'h0, 0, 1);
  endtask

  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      beklenen_t e;
      e = q.pop_front();
      kontrol("gecerli", 32'(ongoru_gecerli_o), 32'(e.g));
      kontrol("atladi", 32'(ongoru_atladi_o), 32'(e.a));
      kontrol("hedef", ongoru_hedef_o, e.h);
      kontrol("sayac_dallanma", sayac_dallanma_o, e.sd);
      kontrol("sayac_hata", sayac_hata_o, e.sh);
    end
  end

  initial begin
    logic [31:0] ps, gps, gh;
    model_reset();
    @(posedge clk_i);
    #1;
    sifirla();

    // Cold predictor: fall through.
    bos(32'h100);

    // Taken update, then lookups on same and aliasing tag.
    adim(32'h100, 1, 1, 32'h100, 32'h80, 0, 0);
    bos(32'h100);
    bos(32'h180);

    // Counter underflow saturation then recovery.
    sifirla();
    repeat (5) adim(32'h100, 1, 0, 32'h100, 32'h0, 0, 0);
    adim(32'h100, 1, 1, 32'h100, 32'h40, 0, 0);
    bos(32'h100);

    // Mispredict strobe ignored without a valid update.
    sifirla();
    adim(32'h200, 1, 0, 32'h200, 32'h0, 1, 0);
    adim(32'h200, 0, 0, 32'h200, 32'h0, 1, 0);
    adim(32'h200, 1, 1, 32'h204, 32'h300, 1, 0);
    adim(32'h200, 1, 0, 32'h208, 32'h0, 1, 0);
    bos(32'h200);

    // Same-cycle update and lookup, then mid-cycle reset.
    sifirla();
    adim(32'h100, 1, 1, 32'h100, 32'h80, 0, 0);
    bos(32'h100);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    kontrol("async_gecerli", 32'(ongoru_gecerli_o), 32'd0);
    kontrol("async_hedef", ongoru_hedef_o, 32'h104);
    kontrol("async_sayac", sayac_dallanma_o, 32'd0);
    @(posedge clk_i);
    #1;
    sifirla();

    // Strongly trained loop branch must predict its target.
    repeat (8) adim(32'h400, 1, 1, 32'h400, 32'h3C0, 0, 0);
    bos(32'h400);

    // Random traffic over a small address pool to force aliasing.
    for (int n = 0; n < 3000; n++) begin
      ps  = 32'h1000 + ($urandom_range(0, 3) << 7) +
            ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
      gps = 32'h1000 + ($urandom_range(0, 3) << 7) +
            ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
      gh  = $urandom();
      adim(ps, ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
           gps, gh, $urandom_range(0, 1), ($urandom_range(0, 199) == 0));
    end

    bos(32'hFFFF_FFFC);
    @(negedge clk_i);
    #1;
    if (q.size() != 0) kontrol("kuyruk_bos", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             karsilastirma, hata_sayisi);
    $finish;
  end

endmodule

// File: doc/dallanma_ongorucu.md
DALLANMA_ONGORUCU -- requirements
Module: dallanma_ongorucu

Interface
REQ-001 Parameter BTB_SATIR, 32, number of branch-target-buffer entries (power of two) SHALL be provided.
REQ-002 Parameter PHT_SATIR, 64, number of 2-bit pattern-history counters (power of two) SHALL be provided.
REQ-003 Parameter GGK_BIT, 6, global history register width, equal to log2(PHT_SATIR), SHALL be provided.
REQ-004 One clock; reset is asynchronous and active-high: clk_i  in  1  clock; rst_i  in  1  asynchronous active-high reset.
REQ-005 ps_i  in  32  fetch program counter to predict.
REQ-006 ongoru_gecerli_o  out  1  BTB hit for ps_i.
REQ-007 ongoru_atladi_o  out  1  predicted taken; this is the value carried down the pipeline as dallanma_ongorusu.
REQ-008 ongoru_hedef_o  out  32  next fetch address.
REQ-009 guncelle_gecerli_i  in  1  resolved-branch update strobe from the branch unit.
REQ-010 guncelle_atladi_i  in  1  resolved direction, 1 = taken.
REQ-011 guncelle_ps_i  in  32  PC of the resolved branch.
REQ-012 guncelle_hedef_adresi_i  in  32  resolved target, meaningful only when taken.
REQ-013 dallanma_hata_i  in  1  resolved direction differed from prediction.
REQ-014 sayac_dallanma_o  out  32  resolved-branch count.
REQ-015 sayac_hata_o  out  32  misprediction count.

Function
REQ-016 Prediction SHALL be combinational from ps_i and current state, with zero latency; ps_i[1:0] are ignored.
REQ-017 BTB index = ps[6:2] and tag = ps[31:7]; a hit requires valid=1 and a tag match.
REQ-018 PHT index = ps[7:2] XOR GGK (gshare).
REQ-019 ongoru_atladi_o = hit AND PHT[index][1].
REQ-020 ongoru_hedef_o = BTB target when ongoru_atladi_o=1, otherwise ps_i+4 (mod 2^32).
REQ-021 On a rising clk_i edge with guncelle_gecerli_i=1, the PHT counter at the index computed from guncelle_ps_i and the pre-edge GGK SHALL increment if taken and decrement if not taken.
REQ-022 PHT counters SHALL saturate at 2'b11 and 2'b00 with no wrap-around.
REQ-023 On the same edge GGK SHALL become {GGK[GGK_BIT-2:0], guncelle_atladi_i}.
REQ-024 GGK is non-speculative: it is updated only on resolution.
REQ-025 Taken update: the BTB entry SHALL be written with valid=1, the tag of guncelle_ps_i, and guncelle_hedef_adresi_i; an existing entry at that index is replaced.
REQ-026 Not-taken update: the BTB SHALL be left unchanged.
REQ-027 sayac_dallanma_o SHALL increment on each valid update.
REQ-028 sayac_hata_o SHALL increment when guncelle_gecerli_i AND dallanma_hata_i; dallanma_hata_i without guncelle_gecerli_i is ignored.
REQ-029 Both performance counters SHALL saturate at 32'hFFFFFFFF.
REQ-030 A prediction and an update to the same entry in the same cycle SHALL see pre-edge state; there is no write-through bypass.
REQ-031 guncelle_gecerli_i=0 SHALL leave all state unchanged.

Reset
REQ-032 While rst_i=1, all PHT counters = 2'b01 (weakly not taken), all BTB valid = 0, GGK = 0, and both counters = 0; updates are ignored.
REQ-033 During reset the outputs SHALL be: ongoru_gecerli_o=0, ongoru_atladi_o=0, ongoru_hedef_o=ps_i+4.
REQ-034 BTB tag/target storage need not be reset.
REQ-035 Assertion mid-operation SHALL take effect immediately, without waiting for clk_i.

Structure
REQ-036 A shared package (operations.vh or a sibling header) SHALL hold the counter encodings GUCLU_ATLAMAZ=00, ZAYIF_ATLAMAZ=01, ZAYIF_ATLAR=10, GUCLU_ATLAR=11, plus the tag/index bit positions and the default sizes.
REQ-037 The BTB SHALL be the sub-module dal_hedef_tamponu: read port, write port, valid/tag/target arrays.
REQ-038 The PHT, GGK and performance counters SHALL reside in the top module.

Verification
REQ-039 Reset, then ps_i=32'h100 -> ongoru_gecerli_o=0, ongoru_atladi_o=0, ongoru_hedef_o=32'h104.
REQ-040 Reset; update ps=32'h100, taken, target 32'h80 (PHT[0]->10, GGK->000001) -> ps_i=32'h100 gives gecerli=1, PHT index 1 (01) so atladi=0, hedef=32'h104; sayac_dallanma_o=1.
REQ-041 After REQ-040, ps_i=32'h180 (same BTB index, different tag) -> gecerli=0, hedef=32'h184.
REQ-042 Reset; five not-taken updates at ps=32'h100 (GGK stays 0) -> PHT[0]=00 with no underflow, then one taken update -> PHT[0]=01; sayac_dallanma_o=6.
REQ-043 Four updates with dallanma_hata_i=1, one of them with guncelle_gecerli_i=0 -> sayac_hata_o=3, sayac_dallanma_o=3.
REQ-044 Taken update at ps=32'h100 with ps_i=32'h100 in the same cycle -> gecerli=0 before the edge, 1 after; asserting rst_i between edges clears the outputs within the same cycle.
